// File: rtl/spi_slave_responder_pkg.sv
// ---------------------------------------------------------------------------
// spi_slave_pkg
// Shared types and limits for the SPI slave responder.
//   state_e          : responder FSM state (IDLE / ACTIVE / DONE)
//   SPI_MAX_CHAR_LEN : widest supported transfer, in bits
//   SPI_NUM_SS       : width of the master's slave-select bus
// ---------------------------------------------------------------------------
package spi_slave_pkg;

    localparam int SPI_MAX_CHAR_LEN = 128;
    localparam int SPI_NUM_SS       = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/spi_slave_responder_if.sv
// ---------------------------------------------------------------------------
// spi_slave_responder_if
// SPI pad-side bundle between a master (or bench) and the slave responder.
//   ss_pad_o   : slave selects, active-low, driven by the master
//   sclk_pad_o : serial clock, driven by the master
//   mosi_pad_o : master-out data
//   miso_bit   : slave-out data, driven by the slave
// Modports: master (drives ss/sclk/mosi), slave (drives miso_bit).
// ---------------------------------------------------------------------------
interface spi_slave_responder_if;
    import spi_slave_pkg::*;

    logic [SPI_NUM_SS-1:0] ss_pad_o;
    logic                  sclk_pad_o;
    logic                  mosi_pad_o;
    logic                  miso_bit;

    modport master (
        output ss_pad_o,
        output sclk_pad_o,
        output mosi_pad_o,
        input  miso_bit
    );

    modport slave (
        input  ss_pad_o,
        input  sclk_pad_o,
        input  mosi_pad_o,
        output miso_bit
    );

endinterface

// File: rtl/spi_slave_responder_sync.sv
// ---------------------------------------------------------------------------
// spi_slave_sync
// WIDTH-bit two-flop synchronizer followed by an edge-detect flop.
//   clk, rst : system clock, synchronous active-high reset
//   async_i  : asynchronous inputs
//   sync_o   : synchronized level
//   rise_o   : one-clk pulse on a synchronized 0->1 transition
//   fall_o   : one-clk pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module spi_slave_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value and the chain shifts one stage per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// ---------------------------------------------------------------------------
// spi_slave_responder
// SPI slave clocked by the system clock. Pads are synchronized, MOSI words
// are shifted in and MISO is driven from a preloaded transmit word.
//   clk, rst      : system clock (>= 8x sclk), synchronous active-high reset
//   spi           : pad bundle (slave modport): ss/sclk/mosi in, miso_bit out
//   mosi_smp_neg  : 1 = sample MOSI on sclk fall, 0 = on rise
//   miso_drv_neg  : 1 = update MISO on sclk fall, 0 = on rise
//   lsb           : 1 = LSB first, 0 = MSB first (both directions)
//   tx_data/load  : transmit word and its one-cycle capture strobe
//   rx_data/valid : last completed word, held valid until accepted
//   rx_ready      : consumer accept
//   rx_overrun    : sticky, word completed while rx_valid still set
//   abort_err     : sticky, slave deselected mid-word
//   busy          : high while in ACTIVE
// Optional feature macro SPI_SLAVE_ECHO_EN: each new word transmits the
// previously received word instead of tx_pend; tx_load is then ignored.
// ---------------------------------------------------------------------------
module spi_slave_responder
    import spi_slave_pkg::*;
#(
    parameter int                          CHAR_LEN      = 32,
    parameter int                          SS_IDX        = 0,
    parameter logic [SPI_MAX_CHAR_LEN-1:0] TX_RESET_WORD = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_slave_responder_if.slave  spi,
    input  logic                  mosi_smp_neg,
    input  logic                  miso_drv_neg,
    input  logic                  lsb,
    input  logic [CHAR_LEN-1:0]   tx_data,
    input  logic                  tx_load,
    output logic [CHAR_LEN-1:0]   rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun,
    output logic                  abort_err,
    output logic                  busy
);

    localparam int                  CNT_W  = $clog2(CHAR_LEN + 1);
    localparam logic [CHAR_LEN-1:0] TX_RST = TX_RESET_WORD[CHAR_LEN-1:0];

    function automatic logic first_bit(input logic [CHAR_LEN-1:0] w, input logic lsb_first);
        return lsb_first ? w[0] : w[CHAR_LEN-1];
    endfunction

    // ---------------- synchronizers: {sclk, mosi, ss[SS_IDX]} -------------
    logic [2:0] sync_v, rise_v, fall_v;

    spi_slave_sync #(.WIDTH(3)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i ({spi.sclk_pad_o, spi.mosi_pad_o, spi.ss_pad_o[SS_IDX]}),
        .sync_o  (sync_v),
        .rise_o  (rise_v),
        .fall_o  (fall_v)
    );

    logic sclk_rise, sclk_fall, mosi_s, sel, sel_rise;
    logic sample_edge, drive_edge;
    logic unused_sigs;

    assign sclk_rise   = rise_v[2];
    assign sclk_fall   = fall_v[2];
    assign mosi_s      = sync_v[1];
    assign sel         = ~sync_v[0];
    assign sel_rise    = fall_v[0];  // ss is active-low
    assign sample_edge = mosi_smp_neg ? sclk_fall : sclk_rise;
    assign drive_edge  = miso_drv_neg ? sclk_fall : sclk_rise;
    assign unused_sigs = ^{rise_v[1:0], fall_v[1], spi.ss_pad_o};

    // ---------------- state ----------------------------------------------
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CHAR_LEN-1:0] shift_rx_q, shift_rx_d;
    logic [CHAR_LEN-1:0] shift_tx_q, shift_tx_d;
    logic [CHAR_LEN-1:0] tx_pend_q, tx_pend_d;
    logic [CHAR_LEN-1:0] rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rx_overrun_q, rx_overrun_d;
    logic                abort_err_q, abort_err_d;
    logic                miso_q, miso_d;
    logic [CHAR_LEN-1:0] reload_word;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_rx_q   <= '0;
            shift_tx_q   <= '0;
            tx_pend_q    <= TX_RST;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            abort_err_q  <= 1'b0;
            miso_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_rx_q   <= shift_rx_d;
            shift_tx_q   <= shift_tx_d;
            tx_pend_q    <= tx_pend_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            abort_err_q  <= abort_err_d;
            miso_q       <= miso_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every variable gets a hold default first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_rx_d   = shift_rx_q;
        shift_tx_d   = shift_tx_q;
        tx_pend_d    = tx_pend_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q;
        abort_err_d  = abort_err_q;
        miso_d       = miso_q;

`ifdef SPI_SLAVE_ECHO_EN
        // The word completing in DONE is the one to echo on the next reload.
        reload_word = (state_q == DONE) ? shift_rx_q : tx_pend_q;
        if (state_q == DONE) begin
            tx_pend_d = shift_rx_q;
        end
`else
        // A same-cycle tx_load wins over the held word for this reload.
        reload_word = tx_load ? tx_data : tx_pend_q;
        if (tx_load) begin
            tx_pend_d = tx_data;
        end
`endif

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                miso_d = 1'b1;
                if (sel_rise) begin
                    shift_tx_d = reload_word;
                    bit_cnt_d  = '0;
                    miso_d     = first_bit(reload_word, lsb);
                    state_d    = ACTIVE;
                end
            end

            ACTIVE: begin
                if (!sel) begin
                    // Deselect before any bit moved is a silent cancel.
                    if (bit_cnt_q != '0) begin
                        abort_err_d = 1'b1;
                    end
                    miso_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    // First bit was presented on entry; later drive edges advance.
                    if (drive_edge && bit_cnt_q != '0) begin
                        if (lsb) begin
                            shift_tx_d = shift_tx_q >> 1;
                            miso_d     = shift_tx_q[1];
                        end else begin
                            shift_tx_d = shift_tx_q << 1;
                            miso_d     = shift_tx_q[CHAR_LEN-2];
                        end
                    end
                    if (sample_edge) begin
                        shift_rx_d = lsb ? {mosi_s, shift_rx_q[CHAR_LEN-1:1]}
                                         : {shift_rx_q[CHAR_LEN-2:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(CHAR_LEN - 1)) begin
                            state_d = DONE;
                        end
                    end
                end
            end

            DONE: begin
                rx_data_d  = shift_rx_q;
                rx_valid_d = 1'b1;
                if (rx_valid_q && !rx_ready) begin
                    rx_overrun_d = 1'b1;
                end
                if (sel) begin
                    shift_tx_d = reload_word;
                    bit_cnt_d  = '0;
                    miso_d     = first_bit(reload_word, lsb);
                    state_d    = ACTIVE;
                end else begin
                    bit_cnt_d  = '0;
                    miso_d     = 1'b1;
                    state_d    = IDLE;
                end
            end

            default: begin
                miso_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == ACTIVE);
    end

    assign spi.miso_bit = miso_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_overrun   = rx_overrun_q;
    assign abort_err    = abort_err_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_responder
// Directed bench for spi_slave_responder (CHAR_LEN=32, SS_IDX=0). Acts as
// an SPI master sampling on sclk rise and driving MISO-side on fall, with
// sclk running at 1/16 of clk.
// ---------------------------------------------------------------------------
module tb_spi_slave_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mosi_smp_neg, miso_drv_neg, lsb;
    logic [31:0] tx_data;
    logic        tx_load;
    logic [31:0] rx_data;
    logic        rx_valid, rx_ready, rx_overrun, abort_err, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_slave_responder_if spi_if ();

    spi_slave_responder #(
        .CHAR_LEN (32),
        .SS_IDX   (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spi          (spi_if),
        .mosi_smp_neg (mosi_smp_neg),
        .miso_drv_neg (miso_drv_neg),
        .lsb          (lsb),
        .tx_data      (tx_data),
        .tx_load      (tx_load),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_overrun   (rx_overrun),
        .abort_err    (abort_err),
        .busy         (busy)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [31:0] w);
        tx_data = w;
        tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
    endtask

    task automatic accept_rx();
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
        wait_clk(1);
    endtask

    // Shift nbits; the master captures MISO just before each rising edge.
    task automatic shift_bits(input logic [31:0] word, input int nbits,
                              input logic lsb_first, output logic [31:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            int idx;
            idx = lsb_first ? i : 31 - i;
            spi_if.mosi_pad_o = word[idx];
            wait_clk(8);
            got[idx] = spi_if.miso_bit;
            spi_if.sclk_pad_o = 1'b1;
            wait_clk(8);
            spi_if.sclk_pad_o = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] word, input logic lsb_first,
                         output logic [31:0] got);
        spi_if.ss_pad_o[0] = 1'b0;
        wait_clk(8);
        shift_bits(word, 32, lsb_first, got);
        wait_clk(8);
        spi_if.ss_pad_o[0] = 1'b1;
        wait_clk(8);
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++; if (rx_data !== 32'h0) begin errors++; $display("FAIL %s rx_data got %h want 0", tag, rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL %s rx_valid got %b want 0", tag, rx_valid); end
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL %s rx_overrun got %b want 0", tag, rx_overrun); end
        checks++; if (abort_err !== 1'b0) begin errors++; $display("FAIL %s abort_err got %b want 0", tag, abort_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy got %b want 0", tag, busy); end
        checks++; if (spi_if.miso_bit !== 1'b1) begin errors++; $display("FAIL %s miso got %b want 1", tag, spi_if.miso_bit); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4);
        check_idle_outputs("reset");
    endtask

    task automatic test_msb_first();
        logic [31:0] got;
        load_tx(32'hA5A5_0F0F);
        frame(32'h1234_5678, 1'b0, got);
        checks++; if (rx_data !== 32'h1234_5678) begin errors++; $display("FAIL msb_rx_data got %h want 12345678", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL msb_rx_valid got %b want 1", rx_valid); end
        checks++; if (got !== 32'hA5A5_0F0F) begin errors++; $display("FAIL msb_miso_word got %h want a5a50f0f", got); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL msb_busy_after got %b want 0", busy); end
        accept_rx();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL msb_accept rx_valid got %b want 0", rx_valid); end
    endtask

    task automatic test_lsb_first();
        logic [31:0] got;
        lsb = 1'b1;
        load_tx(32'h8000_0002);
        spi_if.ss_pad_o[0] = 1'b0;
        wait_clk(8);
        checks++; if (spi_if.miso_bit !== 1'b0) begin errors++; $display("FAIL lsb_first_miso got %b want 0", spi_if.miso_bit); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lsb_busy got %b want 1", busy); end
        shift_bits(32'h0000_0001, 32, 1'b1, got);
        wait_clk(8);
        spi_if.ss_pad_o[0] = 1'b1;
        wait_clk(8);
        checks++; if (rx_data !== 32'h0000_0001) begin errors++; $display("FAIL lsb_rx_data got %h want 00000001", rx_data); end
        checks++; if (got !== 32'h8000_0002) begin errors++; $display("FAIL lsb_miso_word got %h want 80000002", got); end
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL lsb_overrun got %b want 0", rx_overrun); end
        accept_rx();
        lsb = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] g1, g2;
        load_tx(32'h1111_2222);
        spi_if.ss_pad_o[0] = 1'b0;
        wait_clk(8);
        shift_bits(32'hCAFE_0001, 32, 1'b0, g1);
        shift_bits(32'h0BAD_F00D, 32, 1'b0, g2);
        wait_clk(8);
        spi_if.ss_pad_o[0] = 1'b1;
        wait_clk(8);
        checks++; if (rx_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL b2b_rx_data got %h want 0badf00d", rx_data); end
        checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %b want 1", rx_overrun); end
        checks++; if (abort_err !== 1'b0) begin errors++; $display("FAIL b2b_abort got %b want 0", abort_err); end
        checks++; if (g1 !== 32'h1111_2222) begin errors++; $display("FAIL b2b_miso_word1 got %h want 11112222", g1); end
        checks++; if (g2 !== 32'h1111_2222) begin errors++; $display("FAIL b2b_miso_word2 got %h want 11112222", g2); end
    endtask

    task automatic test_abort();
        logic [31:0] got;
        // rx_valid is still set from the previous word and must survive.
        spi_if.ss_pad_o[0] = 1'b0;
        wait_clk(8);
        shift_bits(32'hFFFF_0000, 13, 1'b0, got);
        wait_clk(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_mid got %b want 1", busy); end
        spi_if.ss_pad_o[0] = 1'b1;
        wait_clk(8);
        checks++; if (abort_err !== 1'b1) begin errors++; $display("FAIL abort_err got %b want 1", abort_err); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL abort_rx_valid got %b want 1", rx_valid); end
        checks++; if (rx_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL abort_rx_data got %h want 0badf00d", rx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (spi_if.miso_bit !== 1'b1) begin errors++; $display("FAIL abort_miso got %b want 1", spi_if.miso_bit); end
        accept_rx();
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        spi_if.ss_pad_o[0] = 1'b0;
        wait_clk(8);
        shift_bits(32'h5555_AAAA, 20, 1'b0, got);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(1);
        check_idle_outputs("rst_mid");
        spi_if.ss_pad_o[0] = 1'b1;
        wait_clk(8);
        frame(32'h0F0F_1234, 1'b0, got);
        checks++; if (rx_data !== 32'h0F0F_1234) begin errors++; $display("FAIL rst_mid_rx_data got %h want 0f0f1234", rx_data); end
        checks++; if (got !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_mid_miso_word got %h want ffffffff", got); end
        checks++; if (abort_err !== 1'b0) begin errors++; $display("FAIL rst_mid_abort got %b want 0", abort_err); end
        accept_rx();
    endtask

    task automatic test_echo();
        logic [31:0] g1, g2;
        frame(32'hDEAD_BEEF, 1'b0, g1);
        checks++; if (g1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL echo_first_word got %h want ffffffff", g1); end
        accept_rx();
        load_tx(32'h1234_5678);
        frame(32'h0000_0000, 1'b0, g2);
        checks++; if (g2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL echo_second_word got %h want deadbeef", g2); end
        checks++; if (rx_data !== 32'h0) begin errors++; $display("FAIL echo_rx_data got %h want 0", rx_data); end
    endtask

    initial begin
        rst                = 1'b1;
        spi_if.ss_pad_o    = 8'hFF;
        spi_if.sclk_pad_o  = 1'b0;
        spi_if.mosi_pad_o  = 1'b0;
        mosi_smp_neg       = 1'b0;
        miso_drv_neg       = 1'b1;
        lsb                = 1'b0;
        tx_data            = '0;
        tx_load            = 1'b0;
        rx_ready           = 1'b0;

        test_reset();
`ifdef SPI_SLAVE_ECHO_EN
        test_echo();
`else
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_abort();
        test_reset_mid();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- Synthesizable SPI slave on the far side of the SPI pads, clocked by the system clock.
- Samples `ss_pad_o`, `sclk_pad_o` and `mosi_pad_o` through 2-flop synchronizers and shifts in MOSI words.
- Drives `miso_bit` back to the master from a preloaded transmit word.
- Used as the bench's downstream responder and as the non-loopback MISO source.

Parameters:
- CHAR_LEN, 32, bits per transfer (legal 8..128).
- SS_IDX, 0, index of the `ss_pad_o` bit that selects this slave (active-low).
- TX_RESET_WORD, 32'hFFFF_FFFF, transmit word after reset; zero-extended or truncated to CHAR_LEN.

Ports:
- clk  in  1  system clock; must run ≥8x sclk.
- rst  in  1  synchronous reset, active-high.
- ss_pad_o  in  8  slave selects from master, active-low.
- sclk_pad_o  in  1  serial clock from master.
- mosi_pad_o  in  1  master-out data.
- miso_bit  out  1  slave-out data to the MISO mux.
- mosi_smp_neg  in  1  1 = sample MOSI on sclk falling edge; 0 = rising edge.
- miso_drv_neg  in  1  1 = update MISO on sclk falling edge; 0 = rising edge.
- lsb  in  1  1 = LSB first; 0 = MSB first (both directions).
- tx_data  in  CHAR_LEN  word to transmit.
- tx_load  in  1  one-cycle strobe capturing `tx_data`.
- rx_data  out  CHAR_LEN  last completed received word.
- rx_valid  out  1  high while `rx_data` is unread.
- rx_ready  in  1  consumer accept; transfer occurs when rx_valid & rx_ready.
- rx_overrun  out  1  sticky: word completed while rx_valid still high.
- abort_err  out  1  sticky: ss deasserted mid-word.
- busy  out  1  high in ACTIVE state.

Behaviour:
- **Reset** (rst=1 at a clk edge):
  - State IDLE; synchronizers and bit counter cleared.
  - tx_pend = TX_RESET_WORD.
  - rx_data=0, rx_valid=0, rx_overrun=0, abort_err=0, busy=0, miso_bit=1.
  - Reset mid-transfer discards the partial word with no flags raised.
- **Synchronization and edge detect:**
  - Each input passes through 2 flops; a third flop provides edge detection.
  - sel = ~ss_sync[SS_IDX].
  - Edge pulses are one clk wide, 3 clk after the pad edge.
- **State IDLE:**
  - On sel rising: shift_tx ← tx_pend; bit_cnt ← 0; miso_bit ← first bit (bit 0 if lsb, else bit CHAR_LEN-1); go to ACTIVE.
  - The first bit is valid before any sclk edge.
- **State ACTIVE:**
  - Sample edge (selected by mosi_smp_neg): shift the synchronized MOSI into shift_rx at the end given by lsb (lsb=1 fills from the MSB down); bit_cnt+1.
  - Drive edge (selected by miso_drv_neg), bit_cnt ≠ 0: miso_bit ← next tx bit.
  - When bit_cnt reaches CHAR_LEN on a sample edge: go to DONE.
- **State DONE (1 cycle):**
  - rx_data ← shift_rx.
  - If rx_valid is already set and not being accepted in this same cycle, set rx_overrun and overwrite rx_data.
  - rx_valid ← 1.
  - If sel is still high, reload shift_tx ← tx_pend, bit_cnt ← 0, go to ACTIVE (back-to-back words in one ss frame); else go to IDLE.
- **Mid-word deselect:** sel falls in ACTIVE with 0 < bit_cnt < CHAR_LEN → set abort_err, drop the partial word, go to IDLE. bit_cnt = 0 on deselect is silent.
- **miso_bit when idle:** 1 in IDLE.
- **rx handshake:** rx_valid clears the cycle after rx_valid & rx_ready. Simultaneous accept and DONE: new word loads, rx_valid stays 1, no overrun.
- **tx_load:** may arrive in any state and updates tx_pend only. It never alters the word being shifted. tx_load in the same cycle as DONE: the new value is used for the reload.
- **Sticky flags:** cleared only by rst.

Optional Feature:
- Macro: SPI_SLAVE_ECHO_EN.
- Defined: each reload (IDLE→ACTIVE or DONE→ACTIVE) transmits the previously completed received word instead of tx_pend. The first word after reset transmits TX_RESET_WORD. tx_load is ignored.
- Undefined: transmit source is tx_pend as described above.

Decomposition:
- Package spi_slave_pkg:
  - State enum typedef {IDLE, ACTIVE, DONE}.
  - SPI_MAX_CHAR_LEN=128.
  - SPI_NUM_SS=8.
- Sub-module spi_slave_sync: parameterizable-width 2-flop synchronizer plus edge-detect stage, outputs rise/fall pulses. Instantiated once for {sclk, mosi, ss[SS_IDX]}.

Test Plan:
- **MSB-first word:** CHAR_LEN=32, tx_load 32'hA5A5_0F0F; master sends 32'h1234_5678 with mosi_smp_neg=0, miso_drv_neg=1, lsb=0 → rx_data=32'h1234_5678, rx_valid=1; master receives 32'hA5A5_0F0F.
- **LSB first:** lsb=1, master sends 32'h0000_0001 → rx_data=32'h0000_0001; first MISO bit is tx bit 0.
- **Back-to-back with overrun:** two words in one ss frame, rx_ready held 0 → second rx_data captured, rx_overrun=1, no abort_err.
- **Mid-word deselect:** ss deasserted after 13 sclk cycles → abort_err=1, rx_valid unchanged, state IDLE, miso_bit=1.
- **Reset mid-transfer:** rst at bit 20 → all outputs at reset values; the next full transfer completes normally and transmits TX_RESET_WORD.
- **Echo build:** SPI_SLAVE_ECHO_EN defined, master sends 32'hDEAD_BEEF then 32'h0 → second transfer returns 32'hDEAD_BEEF on MISO.
